l2_nn_sched: RTL and testbench
==============================

Name: l2_nn_sched

Overview:
- Scheduler that time-shares one pipelined FP16 L2-distance unit across N_CAND candidate elements against one query element.
- Accepts a packed candidate vector and a query, then issues one candidate per cycle to the external distance unit.
- Aligns the returned results by index, tracks the running minimum, and reports the argmin index and the minimum distance over a valid/ready handshake.
- Sits between the search front-end and a single shared distance unit; it replaces per-element replicated distance units.

Parameters:
- N_CAND, 7, number of 16-bit candidates packed in cand_vec.
- W, 16, element width (IEEE FP16).
- LAT, 2, fixed latency of the distance unit in cycles (dist_vld at cycle t -> dist_res valid at t+LAT); must be >= 1.
- IDX_W, 3, index width; must satisfy 2^IDX_W >= N_CAND.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_vld  input  1  a new search request is present.
- start_rdy  output  1  scheduler can accept a request; high only in IDLE.
- cand_vec  input  N_CAND*W  candidates; candidate i occupies bits [i*W +: W].
- query  input  W  query element.
- dist_a  output  W  candidate operand to the distance unit.
- dist_b  output  W  query operand to the distance unit.
- dist_vld  output  1  operand issue strobe.
- dist_res  input  W  distance result; sampled only on the aligned return slot.
- res_vld  output  1  result available.
- res_rdy  input  1  consumer accepts the result.
- res_idx  output  IDX_W  index of the minimum distance.
- res_min  output  W  minimum distance (FP16).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE. Issue counter, return counter, tag pipeline, res_idx and res_min are all cleared to 0.
  - Outputs: res_vld=0, dist_vld=0, busy=0, start_rdy=1 once rst_n is released.
  - Reset asserted mid-search abandons the search. Distance results still in flight are ignored because the tag pipeline has been cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on start_vld & start_rdy. cand_vec and query are latched into internal registers on that edge. Inputs are don't-care afterwards.
  - ISSUE: each cycle drive dist_vld=1, dist_a=cand[i], dist_b=query, and push tag {1,i} into a LAT-deep shift pipeline. Index i runs 0..N_CAND-1. After issuing i=N_CAND-1, go to DRAIN.
  - DRAIN: dist_vld=0. Go to DONE on the cycle the tag for index N_CAND-1 is consumed.
  - DONE: res_vld=1, with res_idx/res_min held stable. On res_vld & res_rdy, go to IDLE and clear res_vld on the next edge.
  - start_vld while busy: ignored, with no latching. res_rdy outside DONE: ignored.
- Return handling: on each cycle where the pipeline output tag is valid, sample dist_res as the distance of that tag's index.
  - First return of a search (index 0): load it unconditionally.
  - Later returns replace the stored minimum only if strictly less. Ties keep the lower index.
- Compare rule: distances are non-negative.
  - Compare on the 15-bit magnitude {exp,mant} as unsigned. The sign bit is ignored, so -0 equals +0.
  - A NaN (exp=0x1F, mant!=0) is greater than every value, including +Inf. A NaN never replaces a stored minimum.
  - Between two NaNs, the first one stored is kept.
  - res_min outputs the stored raw 16-bit value unmodified.
- Timing: request accepted at edge T.
  - Issues occur on cycles T+1..T+N_CAND.
  - The last return occurs at T+N_CAND+LAT.
  - res_vld rises at T+N_CAND+LAT+1.
  - Minimum turnaround is N_CAND+LAT+2 cycles per search with res_rdy tied high.

Optional Feature:
- Macro: L2_NN_THRESH_EN.
- When defined:
  - Extra input port thresh [W] is latched alongside query at start.
  - Extra output res_hit [1] equals 1 when the magnitude of res_min is strictly less than the magnitude of thresh, using the same compare rule as above (a NaN thresh gives res_hit=1 unless res_min is NaN).
  - res_hit is valid with res_vld and resets to 0.
- When undefined: both ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-ISSUE -> res_vld=0, dist_vld=0, busy=0 immediately. After release, start_rdy=1 and no stale result appears.
- Basic min: bench model returns scripted distances {0x4000,0x3C00,0x3800,0x4200,0x3A00,0x4400,0x3E00} for indices 0..6 with LAT=2 -> res_idx=2, res_min=0x3800, res_vld at T+10.
- Tie and zero: returns {0x3C00,0x8000,0x0000,0x3C00,...} -> res_idx=1, res_min=0x8000 (-0 is not less than +0, so index 1 is kept).
- NaN: index 0 returns 0x7E00 and the others return 0x7C00 except index 5, which returns 0x3C00 -> res_idx=5, res_min=0x3C00. All-NaN returns -> res_idx=0.
- Backpressure/overlap: hold res_rdy=0 for 5 cycles in DONE while pulsing start_vld -> res outputs stable, start_rdy=0, start not latched. After the handshake, the next search completes correctly.
- L2_NN_THRESH_EN: thresh=0x3C00 with min 0x3800 -> res_hit=1; thresh=0x3800 with min 0x3800 -> res_hit=0.

Source files
------------

// File: rtl/l2_nn_sched.sv
// l2_nn_sched: nearest-neighbour scheduler that time-shares one pipelined
// FP16 L2-distance unit across N_CAND candidate elements against one query.
//
// A request latches cand_vec/query, then one candidate per cycle is issued
// to the external distance unit. Results return LAT cycles later and are
// matched to their candidate index by a tag shift pipeline. The scheduler
// keeps the running minimum and presents the argmin index and minimum
// distance over a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start_vld/start_rdy  request handshake (start_rdy high only when idle)
//   cand_vec, query      candidate i at cand_vec[i*W +: W], query element
//   dist_a/dist_b        operands to the distance unit, dist_vld strobe
//   dist_res             distance result, sampled on the aligned slot only
//   res_vld/res_rdy      result handshake
//   res_idx, res_min     argmin index and raw minimum distance
//   busy                 high whenever not idle
//
// Optional feature (macro L2_NN_THRESH_EN): adds input thresh, latched with
// query, and output res_hit = (|res_min| < |thresh|) under the same compare
// rule, valid with res_vld.

module l2_nn_sched #(
  parameter int N_CAND = 7,
  parameter int W      = 16,
  parameter int LAT    = 2,
  parameter int IDX_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_vld,
  output logic                start_rdy,
  input  logic [N_CAND*W-1:0] cand_vec,
  input  logic [W-1:0]        query,
`ifdef L2_NN_THRESH_EN
  input  logic [W-1:0]        thresh,
  output logic                res_hit,
`endif
  output logic [W-1:0]        dist_a,
  output logic [W-1:0]        dist_b,
  output logic                dist_vld,
  input  logic [W-1:0]        dist_res,
  output logic                res_vld,
  input  logic                res_rdy,
  output logic [IDX_W-1:0]    res_idx,
  output logic [W-1:0]        res_min,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int               MANT_W   = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  state_t              state_q;
  state_t              state_d;
  logic [N_CAND*W-1:0] cand_q;
  logic [W-1:0]        query_q;
  logic [IDX_W-1:0]    issue_idx;
  logic [LAT-1:0]      tag_vld;
  logic [IDX_W-1:0]    tag_idx [LAT];
  logic                ret_vld;
  logic [IDX_W-1:0]    ret_idx;
  logic                accept;
  logic                issue;

  // Magnitude compare a < b on {exp,mant}; the sign is ignored so -0 == +0.
  // A NaN ranks above every value (including Inf), so a NaN is never less
  // than anything and two NaNs compare equal (the first stored is kept).
  function automatic logic mag_less(input logic [W-1:0] a, input logic [W-1:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (&a[W-2:MANT_W]) && (|a[MANT_W-1:0]);
    b_nan = (&b[W-2:MANT_W]) && (|b[MANT_W-1:0]);
    if (a_nan)
      mag_less = 1'b0;
    else if (b_nan)
      mag_less = 1'b1;
    else
      mag_less = (a[W-2:0] < b[W-2:0]);
  endfunction

  assign accept  = (state_q == IDLE) && start_vld;
  assign issue   = (state_q == ISSUE);
  assign ret_vld = tag_vld[LAT-1];
  assign ret_idx = tag_idx[LAT-1];
  assign dist_a  = cand_q[int'(issue_idx)*W +: W];
  assign dist_b  = query_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and state-decoded outputs. DRAIN waits for the tag of the
  // last candidate rather than counting cycles, so the exit is tied to the
  // actual return slot for any LAT.
  always_comb begin
    state_d   = state_q;
    start_rdy = 1'b0;
    busy      = 1'b1;
    dist_vld  = 1'b0;
    res_vld   = 1'b0;
    case (state_q)
      IDLE: begin
        start_rdy = 1'b1;
        busy      = 1'b0;
        if (start_vld)
          state_d = ISSUE;
      end
      ISSUE: begin
        dist_vld = 1'b1;
        if (issue_idx == LAST_IDX)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (ret_vld && (ret_idx == LAST_IDX))
          state_d = DONE;
      end
      DONE: begin
        res_vld = 1'b1;
        if (res_rdy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; the inputs are only looked at on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q  <= '0;
      query_q <= '0;
    end else if (accept) begin
      cand_q  <= cand_vec;
      query_q <= query;
    end
  end

  // Issue counter walks 0..N_CAND-1 and wraps back to 0 for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      issue_idx <= '0;
    else if (issue)
      issue_idx <= (issue_idx == LAST_IDX) ? '0 : issue_idx + 1'b1;
  end

  // Tag pipeline: one {valid,index} slot per cycle of distance-unit latency,
  // so the tag leaving the last stage lines up with the matching dist_res.
  // Clearing it on reset is what discards results still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int k = 0; k < LAT; k++)
        tag_idx[k] <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_idx[0] <= issue_idx;
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  // Running minimum. Index 0 always loads so stale state from a previous
  // search never leaks in; later returns replace only when strictly less,
  // which keeps the lower index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_idx <= '0;
      res_min <= '0;
    end else if (ret_vld && ((ret_idx == '0) || mag_less(dist_res, res_min))) begin
      res_idx <= ret_idx;
      res_min <= dist_res;
    end
  end

`ifdef L2_NN_THRESH_EN
  logic [W-1:0] thresh_q;

  // Threshold captured alongside the query.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      thresh_q <= '0;
    else if (accept)
      thresh_q <= thresh;
  end

  assign res_hit = (state_q == DONE) && mag_less(res_min, thresh_q);
`endif

endmodule

// File: tb/tb_l2_nn_sched.sv
// tb_l2_nn_sched: self-checking bench for l2_nn_sched. The bench plays the
// distance unit (returning scripted distances LAT cycles after each issue),
// keeps a cycle-count model of the search and an argmin model of the result,
// and compares the DUT against it on every negative clock edge. Directed
// searches add hand-computed literal checks.

module tb_l2_nn_sched;

  localparam int N   = 7;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_vld;
  logic            start_rdy;
  logic [N*16-1:0] cand_vec;
  logic [15:0]     query;
  logic [15:0]     dist_a;
  logic [15:0]     dist_b;
  logic            dist_vld;
  logic [15:0]     dist_res = 16'h0000;
  logic            res_vld;
  logic            res_rdy;
  logic [2:0]      res_idx;
  logic [15:0]     res_min;
  logic            busy;
`ifdef L2_NN_THRESH_EN
  logic [15:0]     thresh;
  logic            res_hit;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] script [N];
  logic [15:0] rsp_pipe [LAT] = '{default: 16'h0000};
  int          rsp_k = 0;

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_cand [N];
  logic [15:0] m_query;
  int          e_idx;
  logic [15:0] e_min;
  bit          e_hit;

  l2_nn_sched #(.N_CAND(N), .W(16), .LAT(LAT), .IDX_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_vld(start_vld),
    .start_rdy(start_rdy),
    .cand_vec (cand_vec),
    .query    (query),
`ifdef L2_NN_THRESH_EN
    .thresh   (thresh),
    .res_hit  (res_hit),
`endif
    .dist_a   (dist_a),
    .dist_b   (dist_b),
    .dist_vld (dist_vld),
    .dist_res (dist_res),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .res_idx  (res_idx),
    .res_min  (res_min),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Ordering key: 15-bit magnitude, with every NaN above all numbers.
  function automatic int key(input logic [15:0] x);
    if ((x[14:10] == 5'h1F) && (x[9:0] != 10'h0))
      return 32'h10000;
    return int'(x[14:0]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc++;

  // Distance-unit stand-in: the k-th issue of a search returns script[k],
  // visible for sampling LAT edges after the issuing edge. Empty slots carry
  // 0x0000 so a misaligned sample would win the minimum and be noticed.
  always @(posedge clk) begin
    logic        v;
    logic [15:0] val;
    v   = dist_vld;
    val = 16'h0000;
    if (start_vld && start_rdy)
      rsp_k = 0;
    if (v) begin
      val = (rsp_k < N) ? script[rsp_k] : 16'h0000;
      rsp_k++;
    end
    #1;
    for (int k = LAT - 1; k > 0; k--)
      rsp_pipe[k] = rsp_pipe[k-1];
    rsp_pipe[0] = val;
    dist_res    = rsp_pipe[LAT-1];
  end

  // Search model: a request is taken when idle, candidate m_cnt is issued in
  // the cycle after the m_cnt-th edge past acceptance, and the result is
  // presented after N+LAT edges until the consumer takes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (start_vld) begin
        m_busy  = 1'b1;
        m_cnt   = 0;
        m_query = query;
        for (int i = 0; i < N; i++)
          m_cand[i] = cand_vec[i*16 +: 16];
        e_idx = 0;
        e_min = script[0];
        for (int i = 1; i < N; i++)
          if (key(script[i]) < key(e_min)) begin
            e_idx = i;
            e_min = script[i];
          end
`ifdef L2_NN_THRESH_EN
        e_hit = key(e_min) < key(thresh);
`else
        e_hit = 1'b0;
`endif
      end
    end else if (!m_done) begin
      m_cnt++;
      if (m_cnt == N + LAT)
        m_done = 1'b1;
    end else if (res_rdy) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_res_vld", 32'(res_vld), 32'd0);
      checkOutput("rst_dist_vld", 32'(dist_vld), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
    end else begin
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("start_rdy", 32'(start_rdy), 32'(!m_busy));
      checkOutput("res_vld", 32'(res_vld), 32'(m_done));
      checkOutput("dist_vld", 32'(dist_vld), 32'(m_busy && !m_done && (m_cnt < N)));
      if (m_busy && !m_done && (m_cnt < N)) begin
        checkOutput("dist_a", 32'(dist_a), 32'(m_cand[m_cnt]));
        checkOutput("dist_b", 32'(dist_b), 32'(m_query));
      end
      if (m_done) begin
        checkOutput("res_idx", 32'(res_idx), 32'(e_idx));
        checkOutput("res_min", 32'(res_min), 32'(e_min));
`ifdef L2_NN_THRESH_EN
        checkOutput("res_hit", 32'(res_hit), 32'(e_hit));
`endif
      end
    end
  end

  // Issue one search (DUT assumed idle) and wait for res_vld. lat is the
  // cycle number, counted from the accepting edge T, in which res_vld is
  // first high (the cycle ending at edge T+lat); -1 on timeout.
  task automatic applyStimulus(input logic [15:0] q, input logic [15:0] th,
                               input logic [15:0] cbase, output int lat);
    int t_acc;
    bit seen;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      cand_vec[i*16 +: 16] = cbase + 16'(i * 16'h0111);
    query = q;
`ifdef L2_NN_THRESH_EN
    thresh = th;
`endif
    start_vld = 1'b1;
    t_acc = cyc + 1;
    @(posedge clk);
    #1;
    start_vld = 1'b0;
    cand_vec  = {N{16'hDEAD}};
    query     = 16'hBEEF;
`ifdef L2_NN_THRESH_EN
    thresh = ~th;
`endif
    seen = 1'b0;
    lat  = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (res_vld) begin
        seen = 1'b1;
        lat  = cyc - t_acc + 1;
      end
    end
    if (!seen)
      checkOutput("res_vld_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    start_vld = 1'b0;
    res_rdy   = 1'b1;
    cand_vec  = '0;
    query     = '0;
`ifdef L2_NN_THRESH_EN
    thresh = '0;
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_start_rdy", 32'(start_rdy), 32'd1);
    checkOutput("post_rst_res_vld", 32'(res_vld), 32'd0);

    // Basic minimum: index 2 holds 0x3800.
    script = '{16'h4000, 16'h3C00, 16'h3800, 16'h4200, 16'h3A00, 16'h4400, 16'h3E00};
    applyStimulus(16'h1234, 16'h3C00, 16'h1000, lat);
    checkOutput("basic_lat", 32'(lat), 32'(N + LAT + 1));
    checkOutput("basic_idx", 32'(res_idx), 32'd2);
    checkOutput("basic_min", 32'(res_min), 32'h3800);
`ifdef L2_NN_THRESH_EN
    checkOutput("thresh_hit_3c00", 32'(res_hit), 32'd1);
    applyStimulus(16'h1234, 16'h3800, 16'h1000, lat);
    checkOutput("thresh_hit_3800", 32'(res_hit), 32'd0);
`endif

    // Tie and signed zero: -0 at index 1 is not beaten by +0 at index 2.
    script = '{16'h3C00, 16'h8000, 16'h0000, 16'h3C00, 16'h3E00, 16'h4000, 16'h4200};
    applyStimulus(16'h0042, 16'h0000, 16'h2000, lat);
    checkOutput("tie_idx", 32'(res_idx), 32'd1);
    checkOutput("tie_min", 32'(res_min), 32'h8000);

    // NaN ranks above Inf; the finite value at index 5 wins.
    script = '{16'h7E00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h7C00, 16'h3C00, 16'h7C00};
    applyStimulus(16'h3C00, 16'h7E00, 16'h3000, lat);
    checkOutput("nan_idx", 32'(res_idx), 32'd5);
    checkOutput("nan_min", 32'(res_min), 32'h3C00);

    // All NaN (including a negative NaN): the first one is kept.
    script = '{16'h7E00, 16'h7C01, 16'hFE00, 16'h7FFF, 16'h7E01, 16'h7D00, 16'h7E00};
    applyStimulus(16'h5555, 16'h7E00, 16'h4000, lat);
    checkOutput("allnan_idx", 32'(res_idx), 32'd0);
    checkOutput("allnan_min", 32'(res_min), 32'h7E00);

    // Reset in the middle of issuing abandons the search immediately.
    script = '{16'h4000, 16'h3C00, 16'h3800, 16'h4200, 16'h3A00, 16'h4400, 16'h3E00};
    @(posedge clk);
    #1 start_vld = 1'b1;
    @(posedge clk);
    #1 start_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_res_vld", 32'(res_vld), 32'd0);
    checkOutput("midrst_dist_vld", 32'(dist_vld), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("midrst_start_rdy", 32'(start_rdy), 32'd1);
    checkOutput("midrst_no_stale", 32'(res_vld), 32'd0);

    // Backpressure: result held while start_vld pulses and is ignored.
    script = '{16'h4400, 16'h4200, 16'h4000, 16'h3E00, 16'h3C00, 16'h3A00, 16'h3800};
    res_rdy = 1'b0;
    applyStimulus(16'h0F0F, 16'h3A00, 16'h5000, lat);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      start_vld = (n % 2 == 0);
      cand_vec  = {N{16'(n * 16'h0101)}};
      @(negedge clk);
      checkOutput("bp_start_rdy", 32'(start_rdy), 32'd0);
      checkOutput("bp_idx", 32'(res_idx), 32'd6);
      checkOutput("bp_min", 32'(res_min), 32'h3800);
    end
    @(posedge clk);
    #1;
    start_vld = 1'b0;
    res_rdy   = 1'b1;

    // Next search after the handshake; tie at the minimum keeps index 3.
    script = '{16'h3000, 16'h3000, 16'h3400, 16'h2C00, 16'h2C00, 16'h3000, 16'h3000};
    applyStimulus(16'h7777, 16'h2C00, 16'h6000, lat);
    checkOutput("after_bp_lat", 32'(lat), 32'(N + LAT + 1));
    checkOutput("after_bp_idx", 32'(res_idx), 32'd3);
    checkOutput("after_bp_min", 32'(res_min), 32'h2C00);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
